// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 CTR framer: block/key sizes, FSM state type, popcount helper.
package aes_pkg;

  localparam int AES_BLOCK_SIZE  = 128;
  localparam int AES_KEY_LENGTH  = 256;
  localparam int IN_WIDTH        = 32;
  localparam int WORDS_PER_BLOCK = AES_BLOCK_SIZE / IN_WIDTH;

  // One-hot so each state decode is a single flop bit
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_KEY_LO  = 6'b000010,
    ST_KEY_HI  = 6'b000100,
    ST_COUNTER = 6'b001000,
    ST_ACCUM   = 6'b010000,
    ST_TEXT    = 6'b100000
  } framer_state_t;

  function automatic logic [2:0] popcount4(input logic [3:0] k);
    return 3'(k[0]) + 3'(k[1]) + 3'(k[2]) + 3'(k[3]);
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// Packs up to four 32-bit payload words into one 128-bit block with byte keep; block closes on the 4th word or tlast.
// Latency: block visible the cycle after its closing word; no backpressure of its own (writer gates wr_en).
module aes_word_packer
  import aes_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst,
  input  logic         wr_en,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   wr_keep,
  input  logic         wr_last,
  input  logic         clr,
  output logic [127:0] blk_data,
  output logic [15:0]  blk_keep,
  output logic         blk_last,
  output logic         blk_done
);

  logic [1:0] word_idx;

  assign blk_done = wr_en && ((word_idx == 2'(WORDS_PER_BLOCK - 1)) || wr_last);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      blk_data <= '0;
      blk_keep <= '0;
      blk_last <= 1'b0;
      word_idx <= '0;
    end else if (clr) begin
      blk_data <= '0;
      blk_keep <= '0;
      blk_last <= 1'b0;
      word_idx <= '0;
    end else if (wr_en) begin
      blk_data[32*word_idx +: 32] <= wr_data;
      blk_keep[4*word_idx +: 4]   <= wr_keep;
      word_idx                    <= word_idx + 2'd1;
      if (wr_last)
        blk_last <= 1'b1;
    end
  end

endmodule

// File: rtl/aes256_ctr_framer.sv
// Feeds the AES-256 CTR core: key lo, key hi, IV, then packed 128-bit text beats; >=5 cycles per full block, output held under backpressure.
// Optional length check against Cmd_length is built when AES_FRAMER_LENGTH_CHECK_EN is defined.
module aes256_ctr_framer
  import aes_pkg::*;
#(
  parameter int IN_WIDTH = aes_pkg::IN_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    Cmd_valid,
  output logic                    Cmd_ready,
  input  logic [AES_KEY_LENGTH-1:0] Cmd_key,
  input  logic [AES_BLOCK_SIZE-1:0] Cmd_iv,
  input  logic                    Cmd_encrypt,
  input  logic [15:0]             Cmd_length,
  input  logic                    S_axis_tvalid,
  output logic                    S_axis_tready,
  input  logic [IN_WIDTH-1:0]     S_axis_tdata,
  input  logic [IN_WIDTH/8-1:0]   S_axis_tkeep,
  input  logic                    S_axis_tlast,
  output logic                    M_axis_tvalid,
  input  logic                    M_axis_tready,
  output logic [AES_BLOCK_SIZE-1:0] M_axis_tdata,
  output logic [15:0]             M_axis_tkeep,
  output logic                    M_axis_tlast,
  output logic                    M_axis_tuser,
  output logic                    Length_err
);

  framer_state_t state, state_nxt;

  logic [AES_KEY_LENGTH-1:0] key_q;
  logic [AES_BLOCK_SIZE-1:0] iv_q;
  logic                      enc_q;

  logic         cmd_acc;
  logic         wr_en;
  logic         clr;
  logic [127:0] blk_data;
  logic [15:0]  blk_keep;
  logic         blk_last;
  logic         blk_done;

  // Gated by Rst so no command is seen as accepted while reset is held
  assign Cmd_ready     = (state == ST_IDLE) && !Rst;
  assign S_axis_tready = (state == ST_ACCUM);
  assign cmd_acc       = Cmd_valid && Cmd_ready;
  assign wr_en         = S_axis_tvalid && S_axis_tready;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= ST_IDLE;
      key_q <= '0;
      iv_q  <= '0;
      enc_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cmd_acc) begin
        key_q <= Cmd_key;
        iv_q  <= Cmd_iv;
        enc_q <= Cmd_encrypt;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    M_axis_tvalid = 1'b0;
    M_axis_tdata  = '0;
    M_axis_tkeep  = '0;
    M_axis_tlast  = 1'b0;
    M_axis_tuser  = 1'b0;
    clr           = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (cmd_acc)
          state_nxt = ST_KEY_LO;
      end
      ST_KEY_LO: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = key_q[127:0];
        M_axis_tkeep  = 16'hFFFF;
        M_axis_tuser  = enc_q;
        if (M_axis_tready)
          state_nxt = ST_KEY_HI;
      end
      ST_KEY_HI: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = key_q[255:128];
        M_axis_tkeep  = 16'hFFFF;
        M_axis_tuser  = enc_q;
        if (M_axis_tready)
          state_nxt = ST_COUNTER;
      end
      ST_COUNTER: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = iv_q;
        M_axis_tkeep  = 16'hFFFF;
        M_axis_tuser  = enc_q;
        if (M_axis_tready)
          state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (blk_done)
          state_nxt = ST_TEXT;
      end
      ST_TEXT: begin
        M_axis_tvalid = 1'b1;
        M_axis_tdata  = blk_data;
        M_axis_tkeep  = blk_keep;
        M_axis_tlast  = blk_last;
        M_axis_tuser  = enc_q;
        if (M_axis_tready) begin
          clr       = 1'b1;
          state_nxt = blk_last ? ST_IDLE : ST_ACCUM;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  aes_word_packer u_packer (
    .Clk      (Clk),
    .Rst      (Rst),
    .wr_en    (wr_en),
    .wr_data  (S_axis_tdata),
    .wr_keep  (S_axis_tkeep),
    .wr_last  (S_axis_tlast),
    .clr      (clr),
    .blk_data (blk_data),
    .blk_keep (blk_keep),
    .blk_last (blk_last),
    .blk_done (blk_done)
  );

`ifdef AES_FRAMER_LENGTH_CHECK_EN
  logic [15:0] byte_cnt;
  logic [15:0] len_q;
  logic        len_err_q;
  logic [16:0] byte_sum;
  logic [15:0] byte_sum_sat;

  assign byte_sum     = 17'(byte_cnt) + 17'(popcount4(S_axis_tkeep));
  assign byte_sum_sat = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
  assign Length_err   = len_err_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      byte_cnt  <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= wr_en && S_axis_tlast && (byte_sum_sat != len_q);
      if (cmd_acc) begin
        byte_cnt <= '0;
        len_q    <= Cmd_length;
      end else if (wr_en) begin
        byte_cnt <= byte_sum_sat;
      end
    end
  end
`else
  logic unused_cmd_length;
  assign unused_cmd_length = ^Cmd_length;
  assign Length_err        = 1'b0;
`endif

endmodule

// File: tb/tb_aes256_ctr_framer.sv
// Randomized self-checking bench for aes256_ctr_framer against a byte-level framing model.
module tb_aes256_ctr_framer;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Cmd_valid;
  logic         Cmd_ready;
  logic [255:0] Cmd_key;
  logic [127:0] Cmd_iv;
  logic         Cmd_encrypt;
  logic [15:0]  Cmd_length;
  logic         S_axis_tvalid;
  logic         S_axis_tready;
  logic [31:0]  S_axis_tdata;
  logic [3:0]   S_axis_tkeep;
  logic         S_axis_tlast;
  logic         M_axis_tvalid;
  logic         M_axis_tready;
  logic [127:0] M_axis_tdata;
  logic [15:0]  M_axis_tkeep;
  logic         M_axis_tlast;
  logic         M_axis_tuser;
  logic         Length_err;

  aes256_ctr_framer dut (
    .Clk(Clk), .Rst(Rst),
    .Cmd_valid(Cmd_valid), .Cmd_ready(Cmd_ready), .Cmd_key(Cmd_key), .Cmd_iv(Cmd_iv),
    .Cmd_encrypt(Cmd_encrypt), .Cmd_length(Cmd_length),
    .S_axis_tvalid(S_axis_tvalid), .S_axis_tready(S_axis_tready), .S_axis_tdata(S_axis_tdata),
    .S_axis_tkeep(S_axis_tkeep), .S_axis_tlast(S_axis_tlast),
    .M_axis_tvalid(M_axis_tvalid), .M_axis_tready(M_axis_tready), .M_axis_tdata(M_axis_tdata),
    .M_axis_tkeep(M_axis_tkeep), .M_axis_tlast(M_axis_tlast), .M_axis_tuser(M_axis_tuser),
    .Length_err(Length_err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
    logic         u;
  } beat_t;

  int checks = 0;
  int errors = 0;

  beat_t        got_q[$];
  beat_t        exp_q[$];
  byte unsigned msg_q[$];
  int           stab_viol = 0;
  int           sready_viol = 0;
  int           len_pulses = 0;
  int           rdy_mode = 0;
  int           hold_cnt = 0;

  // Monitor: sample mid-cycle, record handshaken beats and protocol violations
  beat_t held;
  bit    held_v = 0;
  always @(negedge Clk) begin
    beat_t cur;
    cur = '{d: M_axis_tdata, k: M_axis_tkeep, l: M_axis_tlast, u: M_axis_tuser};
    if (Rst) begin
      held_v = 0;
    end else begin
      if (M_axis_tvalid && S_axis_tready) sready_viol++;
      if (held_v && (!M_axis_tvalid || cur != held)) stab_viol++;
      if (M_axis_tvalid && M_axis_tready) begin
        got_q.push_back(cur);
        held_v = 0;
      end else if (M_axis_tvalid) begin
        held = cur;
        held_v = 1;
      end
      if (Length_err) len_pulses++;
    end
  end

  // Downstream ready: 0 = always, 1 = random, 2 = low 7 cycles per beat
  always @(posedge Clk) begin
    #1;
    case (rdy_mode)
      0: M_axis_tready = 1'b1;
      1: M_axis_tready = 1'($urandom_range(0, 1));
      default: begin
        if (M_axis_tvalid) begin
          if (hold_cnt == 7) begin
            M_axis_tready = 1'b1;
            hold_cnt = 0;
          end else begin
            M_axis_tready = 1'b0;
            hold_cnt++;
          end
        end else begin
          M_axis_tready = 1'b0;
          hold_cnt = 0;
        end
      end
    endcase
  end

  // Reference: key lo, key hi, IV, then the message bytes cut into 16-byte beats
  function automatic void build_expected(input logic [255:0] key, input logic [127:0] iv, input bit enc);
    int n, nb, idx;
    beat_t b;
    exp_q.delete();
    exp_q.push_back('{d: key[127:0],   k: 16'hFFFF, l: 1'b0, u: enc});
    exp_q.push_back('{d: key[255:128], k: 16'hFFFF, l: 1'b0, u: enc});
    exp_q.push_back('{d: iv,           k: 16'hFFFF, l: 1'b0, u: enc});
    n  = msg_q.size();
    nb = (n == 0) ? 1 : (n + 15) / 16;
    for (int bi = 0; bi < nb; bi++) begin
      b = '0;
      for (int i = 0; i < 16; i++) begin
        idx = bi * 16 + i;
        if (idx < n) begin
          b.d[8*i +: 8] = msg_q[idx];
          b.k[i] = 1'b1;
        end
      end
      b.l = (bi == nb - 1);
      b.u = enc;
      exp_q.push_back(b);
    end
  endfunction

  task automatic send_cmd(input logic [255:0] key, input logic [127:0] iv, input bit enc, input int len);
    bit ok = 0;
    @(posedge Clk); #1;
    Cmd_key = key; Cmd_iv = iv; Cmd_encrypt = enc; Cmd_length = 16'(len); Cmd_valid = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge Clk);
      if (Cmd_ready) ok = 1;
    end
    @(posedge Clk); #1;
    Cmd_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_timeout Cmd_ready got 0 want 1 within 200 cycles");
    end
  endtask

  task automatic send_word(input logic [31:0] dat, input logic [3:0] keep, input bit last);
    bit ok = 0;
    S_axis_tdata = dat; S_axis_tkeep = keep; S_axis_tlast = last; S_axis_tvalid = 1'b1;
    for (int c = 0; c < 500 && !ok; c++) begin
      @(negedge Clk);
      if (S_axis_tready) ok = 1;
    end
    @(posedge Clk); #1;
    S_axis_tvalid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL word_timeout S_axis_tready got 0 want 1 within 500 cycles");
    end
  endtask

  task automatic send_msg(input int gap_max);
    int n, nw, rem;
    logic [31:0] dat;
    logic [3:0]  keep;
    n  = msg_q.size();
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      dat = '0; keep = '0;
      for (int i = 0; i < 4; i++) begin
        if (4 * w + i < n) begin
          dat[8*i +: 8] = msg_q[4*w + i];
          keep[i] = 1'b1;
        end
      end
      rem = $urandom_range(0, gap_max);
      repeat (rem) @(posedge Clk);
      #0;
      send_word(dat, keep, w == nw - 1);
    end
  endtask

  task automatic run_session(input logic [255:0] key, input logic [127:0] iv, input bit enc,
                             input int len, input int gap_max);
    got_q.delete();
    build_expected(key, iv, enc);
    send_cmd(key, iv, enc, len);
    send_msg(gap_max);
    for (int c = 0; c < 3000 && got_q.size() < exp_q.size(); c++) @(negedge Clk);
    repeat (4) @(negedge Clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL beat_count got %0d want %0d", got_q.size(), exp_q.size());
    end
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  function automatic logic [127:0] rand_iv();
    logic [127:0] v;
    for (int i = 0; i < 4; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    Rst = 1'b1;
    #1;
    checks++;
    if ({M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser, S_axis_tready, Cmd_ready, Length_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got vld=%b dat=%h keep=%h last=%b user=%b srdy=%b crdy=%b lerr=%b want all 0",
               M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser, S_axis_tready, Cmd_ready, Length_err);
    end
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    checks++;
    if (Cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_cmd_ready got %b want 1", Cmd_ready);
    end
  endtask

  task automatic test_vector();
    logic [255:0] key;
    logic [127:0] iv;
    for (int i = 0; i < 32; i++) key[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) iv[8*i +: 8] = 8'(8'hF0 + i);
    msg_q.delete();
    for (int i = 0; i < 16; i++) msg_q.push_back(8'(i));
    rdy_mode = 0;
    run_session(key, iv, 1'b1, 16, 0);
    if (got_q.size() == 4) begin
      checks++;
      if (got_q[0] !== {128'h0f0e0d0c0b0a09080706050403020100, 16'hFFFF, 1'b0, 1'b1}) begin
        errors++; $display("FAIL vec_key_lo got %h", got_q[0]);
      end
      checks++;
      if (got_q[1] !== {128'h1f1e1d1c1b1a19181716151413121110, 16'hFFFF, 1'b0, 1'b1}) begin
        errors++; $display("FAIL vec_key_hi got %h", got_q[1]);
      end
      checks++;
      if (got_q[2] !== {128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 16'hFFFF, 1'b0, 1'b1}) begin
        errors++; $display("FAIL vec_iv got %h", got_q[2]);
      end
      checks++;
      if (got_q[3] !== {128'h0f0e0d0c0b0a09080706050403020100, 16'hFFFF, 1'b1, 1'b1}) begin
        errors++; $display("FAIL vec_text got %h", got_q[3]);
      end
    end
  endtask

  task automatic test_twenty_bytes();
    msg_q.delete();
    for (int i = 0; i < 20; i++) msg_q.push_back(8'($urandom));
    rdy_mode = 0;
    run_session(rand_key(), rand_iv(), 1'b0, 20, 1);
    if (got_q.size() == 5) begin
      checks++;
      if (got_q[3].k !== 16'hFFFF || got_q[3].l !== 1'b0) begin
        errors++; $display("FAIL twenty_first_text got keep=%h last=%b want FFFF 0", got_q[3].k, got_q[3].l);
      end
      checks++;
      if (got_q[4].k !== 16'h000F || got_q[4].l !== 1'b1 || got_q[4].d[127:32] !== 96'h0
          || got_q[4].d[31:0] !== {msg_q[19], msg_q[18], msg_q[17], msg_q[16]}) begin
        errors++; $display("FAIL twenty_tail got %h want keep 000F last 1 upper 0", got_q[4]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL twenty_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_zero_length();
    msg_q.delete();
    rdy_mode = 0;
    run_session(rand_key(), rand_iv(), 1'b1, 0, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL zero_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (Cmd_ready !== 1'b1) begin
      errors++; $display("FAIL zero_back_idle Cmd_ready got %b want 1", Cmd_ready);
    end
  endtask

  task automatic test_backpressure();
    msg_q.delete();
    for (int i = 0; i < 28; i++) msg_q.push_back(8'($urandom));
    stab_viol = 0; sready_viol = 0;
    rdy_mode = 2;
    run_session(rand_key(), rand_iv(), 1'b1, 28, 0);
    rdy_mode = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stab_viol != 0) begin
      errors++; $display("FAIL bp_stable violations got %0d want 0", stab_viol);
    end
    checks++;
    if (sready_viol != 0) begin
      errors++; $display("FAIL bp_sready_in_text got %0d want 0", sready_viol);
    end
  endtask

  task automatic test_mid_reset();
    rdy_mode = 0;
    send_cmd(rand_key(), rand_iv(), 1'b1, 16);
    send_word(32'hDEADBEEF, 4'hF, 1'b0);
    send_word(32'hCAFEF00D, 4'hF, 1'b0);
    @(negedge Clk); #2;
    Rst = 1'b1;
    #1;
    checks++;
    if ({M_axis_tvalid, M_axis_tdata, M_axis_tkeep, M_axis_tlast, M_axis_tuser, S_axis_tready, Cmd_ready} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got vld=%b dat=%h keep=%h srdy=%b crdy=%b want all 0",
               M_axis_tvalid, M_axis_tdata, M_axis_tkeep, S_axis_tready, Cmd_ready);
    end
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(8'($urandom));
    run_session(rand_key(), rand_iv(), 1'b0, 5, 0);
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL midreset_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    len_pulses = 0; stab_viol = 0; sready_viol = 0;
    rdy_mode = 1;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(0, 44);
      msg_q.delete();
      for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom));
      run_session(rand_key(), rand_iv(), 1'($urandom_range(0, 1)), n, 2);
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++; $display("FAIL rand%0d_beat%0d got %h want %h", s, i, got_q[i], exp_q[i]);
        end
      end
    end
    rdy_mode = 0;
    checks++;
    if (stab_viol != 0 || sready_viol != 0) begin
      errors++; $display("FAIL rand_protocol got stab=%0d sready=%0d want 0 0", stab_viol, sready_viol);
    end
    checks++;
    if (len_pulses != 0) begin
      errors++; $display("FAIL rand_length_err got %0d pulses want 0", len_pulses);
    end
  endtask

  task automatic test_length();
    int want_bad;
`ifdef AES_FRAMER_LENGTH_CHECK_EN
    want_bad = 1;
`else
    want_bad = 0;
`endif
    rdy_mode = 0;
    msg_q.delete();
    for (int i = 0; i < 17; i++) msg_q.push_back(8'($urandom));
    len_pulses = 0;
    run_session(rand_key(), rand_iv(), 1'b1, 18, 0);
    checks++;
    if (len_pulses != want_bad) begin
      errors++; $display("FAIL len_mismatch pulses got %0d want %0d", len_pulses, want_bad);
    end
    len_pulses = 0;
    run_session(rand_key(), rand_iv(), 1'b1, 17, 0);
    checks++;
    if (len_pulses != 0) begin
      errors++; $display("FAIL len_match pulses got %0d want 0", len_pulses);
    end
  endtask

  initial begin
    Rst = 1'b1;
    Cmd_valid = 1'b0; Cmd_key = '0; Cmd_iv = '0; Cmd_encrypt = 1'b0; Cmd_length = '0;
    S_axis_tvalid = 1'b0; S_axis_tdata = '0; S_axis_tkeep = '0; S_axis_tlast = 1'b0;
    M_axis_tready = 1'b1;
    test_reset();
    test_vector();
    test_twenty_bytes();
    test_zero_length();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_length();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
